// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO.
// Bytes enter through a valid/ready handshake, queue in a circular buffer
// and are shifted out LSB first, one bit every CLKS_PER_BIT clocks.
// Consecutive queued bytes go out back-to-back with no idle gap.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // FIFO storage and pointers (one extra MSB distinguishes full from empty)
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        tx_ready_q;

    // Transmit FSM state
    state_t      state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;

    logic        push;
    logic        pop;
    logic        empty;
    logic        full_d;
    logic        baud_done;
    logic [7:0]  head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = tx_valid && tx_ready_q;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

    // tx_ready is a flop, so it is loaded with the fullness the pointers
    // will have after this edge; that keeps it equal to !full every cycle.
    assign full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                    (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

    assign baud_done = (baud_q == BAUD_LAST);

    // Byte storage: written on every accepted push, never reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= tx_data;
        end
    end

    // FIFO pointers and the registered ready flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_ready_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_ready_q <= !full_d;
        end
    end

    // Next-state logic: frame sequencing, bit timing and FIFO pops
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end

            S_DATA: begin
                // bit_q is the index of the data bit currently on the line
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end

            S_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!empty) begin
                        // Chain straight into the next start bit
                        pop     = 1'b1;
                        shift_d = head;
                        bit_d   = '0;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end

            default: begin
                tx_d    = 1'b1;
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM control registers; reset abandons any frame and idles the line
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    // Shift register holds payload only, so it carries no reset
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign tx         = tx_q;
    assign tx_ready   = tx_ready_q;
    assign busy       = (state_q != S_IDLE) || !empty;
    assign fifo_level = wr_ptr_q - rd_ptr_q;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Synthesizable 8N1 UART transmitter with an internal byte FIFO, used as the console/debug output path from the user-project logic to a Caravel GPIO pad. It is the transmit-side counterpart of the simulation UART receiver that decodes the serial line in the DV benches. It accepts bytes through a valid/ready handshake and serialises them LSB first at a fixed bit period.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per serial bit (100 MHz / 115200 baud); legal range ≥ 2.
- FIFO_DEPTH, default 16: byte FIFO depth; must be a power of two ≥ 2.
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data is presented.
- tx_ready  out  1  FIFO can accept a byte; registered; equals !full.
- tx  out  1  serial line to the pad; idle high.
- busy  out  1  high while the FIFO is non-empty or a frame is on the line.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of bytes currently queued, excluding the byte being shifted.

## Operation
- Push: a byte is accepted on a rising edge where tx_valid && tx_ready. tx_valid without tx_ready is ignored; the producer holds the byte.
- FIFO: circular buffer with read/write pointers one bit wider than the address; full = MSBs differ and address bits equal; empty = pointers equal. Pointers wrap modulo 2·FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit counter, drive tx=0, go to START.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then drive bit 0 and go to DATA.
  - DATA: hold each bit for CLKS_PER_BIT cycles, LSB first, shifting right; after bit 7 drive tx=1 and go to STOP.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. At the end of the period, if the FIFO is non-empty, pop and go directly to START with tx=0 (no idle gap); otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and is reloaded on every state/bit transition.
- A push and a pop in the same cycle are both honoured; fifo_level is unchanged. A push in the same cycle that a pop frees a slot in a full FIFO is not accepted, because tx_ready was 0 in that cycle.
- busy = (state != IDLE) || !empty.

## Timing
- Reset values (the cycle after rst is sampled high): tx=1, tx_ready=1, busy=0, fifo_level=0, state IDLE, both pointers 0, counters 0.
- Reset mid-frame: the frame is abandoned and tx is 1 on the next edge. All queued bytes are discarded. A push in the reset cycle is dropped.
- Latency: with the FSM in IDLE, a byte accepted at edge N gives tx=0 from edge N+1, and fifo_level returns to 0 at edge N+1.
- Frame length: exactly 10·CLKS_PER_BIT cycles from the start-bit falling edge to the end of the stop bit.
- tx_ready falls on the edge that makes the FIFO full. It rises on the edge following the first pop from full.
- tx is driven from a flop; no combinational path from any input to tx.

## Test plan
- Single byte, CLKS_PER_BIT=4: push 0x55 from idle -> tx is low 1 cycle after accept. Required sequence: 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles. Then tx stays 1 and busy falls after the 40th cycle.
- Back-to-back, CLKS_PER_BIT=4: push 0xA3, 0x0F on consecutive cycles -> two contiguous 40-cycle frames with no idle cycle between them. Decoded LSB first: 0xA3 then 0x0F.
- Full FIFO, FIFO_DEPTH=4: push 6 bytes (0x01..0x06) back-to-back from idle. 0x01 is popped immediately and 0x02..0x05 fill the FIFO -> tx_ready=0 with fifo_level=4, so 0x06 is held by the producer. Required: 0x06 is accepted only after 0x02 is popped, and all six bytes appear in order.
- Reset mid-frame: push 0xFF and 0x00, then assert rst for 1 cycle during DATA bit 3 -> tx=1 on the next edge, fifo_level=0, busy=0, and no further start bit appears.
- Loopback with the bench UART receiver at 115200 baud (CLKS_PER_BIT=868, 100 MHz): send "OK\n" -> receiver prints "OK" with no framing error.
- Simultaneous push/pop: with fifo_level=2, push on the exact cycle the FSM pops -> fifo_level stays 2 and byte order is preserved.
